heli_motion_ctrl: RTL and testbench
===================================

// Module: heli_motion_ctrl
// PURPOSE
//  Upstream controller for the 10x10 rectangle drawer. Sequences draw -> wait one frame
//  -> erase -> move -> redraw. Owns the object's top-left position (obj_x, obj_y), which
//  the drawer uses as its offset. Applies gravity each frame and a rise when flap was
//  pressed. Detects a floor/ceiling crash and freezes.
// PARAMETERS
//  FRAME_CYCLES  833334  clk cycles per animation frame (50 MHz / 60 Hz)
//  X_START       60      reset/initial obj_x
//  Y_START       50      reset/initial obj_y
//  Y_MIN         0       smallest legal obj_y (ceiling)
//  Y_MAX         109     largest legal obj_y (floor; 120 rows minus 11 drawn rows)
//  RISE_STEP     3       rows moved up per frame with a latched flap
//  FALL_STEP     1       rows moved down per frame without a flap
// PORTS
//  clk          in   1  system clock; single clock domain
//  resetn       in   1  asynchronous, active-low reset
//  go           in   1  start request; level, sampled in IDLE only
//  flap         in   1  player button, already synchronised; active high
//  draw_done    in   1  drawer finished the current pass (registered in drawer)
//  draw_enable  out  1  run the drawer
//  draw_erase   out  1  1 = drawer paints black, 0 = drawer paints object colour
//  obj_x        out  8  object top-left x; constant X_START in this revision
//  obj_y        out  7  object top-left y
//  crashed      out  1  sticky crash flag
// BEHAVIOUR
//  Reset (async, resetn=0): state=IDLE, draw_enable=0, draw_erase=0, obj_x=X_START,
//   obj_y=Y_START, crashed=0, flap_pend=0, frame count=0. All outputs are registered.
//  IDLE: enable/erase are 0. When go=1, go to DRAW on the next edge.
//  DRAW: draw_enable=1, draw_erase=0. On the edge that samples draw_done=1: enable->0;
//   next state is CRASH if crashed=1, otherwise WAIT_FRAME.
//  WAIT_FRAME: enable=0. The frame counter counts 0..FRAME_CYCLES-1. On terminal count it
//   clears to 0 and the state goes to ERASE. Any cycle with flap=1 sets flap_pend.
//  ERASE: draw_enable=1, draw_erase=1, obj_x/obj_y held. On draw_done=1 go to UPDATE
//   with enable->0 and erase->0.
//  UPDATE (exactly 1 cycle):
//   - flap_pend=1: obj_y <= (obj_y < Y_MIN+RISE_STEP) ? Y_MIN : obj_y-RISE_STEP.
//   - otherwise: obj_y <= (obj_y > Y_MAX-FALL_STEP) ? Y_MAX : obj_y+FALL_STEP.
//   - Compute with 8-bit intermediates; no wrap is permitted.
//   - crashed <= 1 if the new obj_y equals Y_MAX, or equals Y_MIN with flap_pend=1.
//   - flap_pend <= 0, unless flap=1 in this same cycle; flap wins and the pend is kept.
//   - Always go to DRAW, so the final position is drawn before freezing.
//  CRASH: terminal state. enable=0, crashed=1, position frozen; go and flap are ignored.
//   Exit is via resetn only.
//  draw_enable never drops mid-pass except on reset. The drawer sees one extra enabled
//   cycle after done; this is allowed.
//  draw_done outside DRAW/ERASE is ignored. flap outside WAIT_FRAME/UPDATE is ignored.
//  Reset mid-pass: all state returns to reset values immediately. The drawer is reset by
//   the same resetn, so no partial-pass handshake survives.
//  Latency: go -> draw_enable=1 is 1 cycle. done -> enable=0 is 1 cycle.
// STRUCTURE
//  Shared package: state encodings (IDLE, DRAW, WAIT_FRAME, ERASE, UPDATE, CRASH; 3 bits)
//   and screen constants SCREEN_W=160, SCREEN_H=120, OBJ_SIZE=10.
//  Sub-module frame_tick_gen: parameter FRAME_CYCLES, counter of width
//   $clog2(FRAME_CYCLES), inputs clk/resetn/run, output a 1-cycle tick. run=0 clears
//   the count.
//  Top level: FSM, position register with saturating update, flap_pend latch, crash flag.
// TESTING (simulate with FRAME_CYCLES=8; drawer model asserts done 5 cycles after enable)
//  1. Reset, then go=1 -> draw_enable=1, erase=0 the next cycle; obj_y=50;
//     after done, WAIT_FRAME lasts 8 cycles.
//  2. No flap for 3 frames -> obj_y steps 51, 52, 53; each step appears only after an
//     ERASE pass completes.
//  3. Pulse flap for 1 cycle mid-WAIT_FRAME with obj_y=53 -> obj_y=50 after UPDATE;
//     the next frame with no flap gives 51.
//  4. Preload obj_y=1 and flap -> obj_y=0 (saturates), crashed=1, one DRAW pass, then
//     CRASH with no further enable.
//  5. Fall to obj_y=108 then 109 -> crashed=1 at 109; go=1 and flap=1 in CRASH cause
//     no state change.
//  6. Assert resetn=0 mid-ERASE -> all outputs return to reset values asynchronously;
//     after release, stays in IDLE until go.

Source files
------------

// File: rtl/heli_motion_ctrl_pkg.sv
// Shared types and screen constants for the helicopter motion controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package heli_motion_ctrl_pkg;

  // Controller sequencing states
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    DRAW       = 3'd1,
    WAIT_FRAME = 3'd2,
    ERASE      = 3'd3,
    UPDATE     = 3'd4,
    CRASH      = 3'd5
  } state_t;

  // Screen geometry shared with the drawer
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int OBJ_SIZE = 10;

endpackage

// File: rtl/heli_motion_ctrl_frame_tick_gen.sv
// Frame pacing counter: single-cycle tick every FRAME_CYCLES cycles while run is high.
// Latency: tick is asserted combinationally on the terminal-count cycle.
// Backpressure: none; run=0 clears the count so each frame starts from zero.
module heli_motion_ctrl_frame_tick_gen #(
  parameter int FRAME_CYCLES = 833334
) (
  input  logic clk,
  input  logic resetn,
  input  logic run,
  output logic tick
);

  localparam int CW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam logic [CW-1:0] TC = CW'(FRAME_CYCLES - 1);

  logic [CW-1:0] cnt;

  assign tick = run && (cnt == TC);

  // Count while running; wrap to zero at terminal count or whenever idle
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (!run || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/heli_motion_ctrl.sv
// Sequences drawer passes (draw, wait a frame, erase, move, redraw) and owns the object position.
// Latency: go -> draw_enable 1 cycle; draw_done -> draw_enable low 1 cycle; all outputs registered.
// Backpressure: each pass holds draw_enable until draw_done; frame waits are fixed-length.
module heli_motion_ctrl
  import heli_motion_ctrl_pkg::*;
#(
  parameter int FRAME_CYCLES = 833334,
  parameter int X_START      = 60,
  parameter int Y_START      = 50,
  parameter int Y_MIN        = 0,
  // floor: screen height minus the 11 rows the drawer actually paints
  parameter int Y_MAX        = SCREEN_H - OBJ_SIZE - 1,
  parameter int RISE_STEP    = 3,
  parameter int FALL_STEP    = 1
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       go,
  input  logic       flap,
  input  logic       draw_done,
  output logic       draw_enable,
  output logic       draw_erase,
  output logic [7:0] obj_x,
  output logic [6:0] obj_y,
  output logic       crashed
);

  localparam logic [7:0] YMIN8    = 8'(Y_MIN);
  localparam logic [7:0] YMAX8    = 8'(Y_MAX);
  localparam logic [7:0] RISE8    = 8'(RISE_STEP);
  localparam logic [7:0] FALL8    = 8'(FALL_STEP);
  localparam logic [7:0] RISE_LIM = 8'(Y_MIN + RISE_STEP);
  localparam logic [7:0] FALL_LIM = 8'(Y_MAX - FALL_STEP);

  state_t     state, state_nxt;
  logic       en_nxt, er_nxt;
  logic       tick;
  logic       flap_pend;
  logic [7:0] y8, y_up, y_dn, y_new;

  heli_motion_ctrl_frame_tick_gen #(
    .FRAME_CYCLES(FRAME_CYCLES)
  ) u_tick (
    .clk    (clk),
    .resetn (resetn),
    .run    (state == WAIT_FRAME),
    .tick   (tick)
  );

  // Saturating move computed at 8 bits so neither direction can wrap
  assign y8    = {1'b0, obj_y};
  assign y_up  = (y8 < RISE_LIM) ? YMIN8 : (y8 - RISE8);
  assign y_dn  = (y8 > FALL_LIM) ? YMAX8 : (y8 + FALL8);
  assign y_new = flap_pend ? y_up : y_dn;

  // Next state plus next values of the registered drawer controls
  always_comb begin
    state_nxt = state;
    en_nxt    = 1'b0;
    er_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (go) begin
          state_nxt = DRAW;
          en_nxt    = 1'b1;
        end
      end
      DRAW: begin
        if (draw_done) begin
          state_nxt = crashed ? CRASH : WAIT_FRAME;
        end else begin
          en_nxt = 1'b1;
        end
      end
      WAIT_FRAME: begin
        if (tick) begin
          state_nxt = ERASE;
          en_nxt    = 1'b1;
          er_nxt    = 1'b1;
        end
      end
      ERASE: begin
        if (draw_done) begin
          state_nxt = UPDATE;
        end else begin
          en_nxt = 1'b1;
          er_nxt = 1'b1;
        end
      end
      UPDATE: begin
        // always redraw, so a crash position is shown before freezing
        state_nxt = DRAW;
        en_nxt    = 1'b1;
      end
      CRASH: begin
        state_nxt = CRASH;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and drawer control registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      draw_enable <= 1'b0;
      draw_erase  <= 1'b0;
    end else begin
      state       <= state_nxt;
      draw_enable <= en_nxt;
      draw_erase  <= er_nxt;
    end
  end

  // Position, pending flap and sticky crash flag
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      obj_x     <= 8'(X_START);
      obj_y     <= 7'(Y_START);
      crashed   <= 1'b0;
      flap_pend <= 1'b0;
    end else begin
      obj_x <= 8'(X_START);
      if (state == WAIT_FRAME && flap) begin
        flap_pend <= 1'b1;
      end
      if (state == UPDATE) begin
        obj_y     <= y_new[6:0];
        // a flap in the update cycle itself carries into the next frame
        flap_pend <= flap;
        if (y_new == YMAX8 || (y_new == YMIN8 && flap_pend)) begin
          crashed <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_heli_motion_ctrl.sv
// Bench for heli_motion_ctrl with a short frame and a 5-cycle drawer model.
// Latency: n/a.
// Backpressure: drawer model answers each enabled pass with a single draw_done pulse.
module tb_heli_motion_ctrl;

  logic       clk = 1'b0;
  logic       resetn = 1'b1;
  logic       go = 1'b0;
  logic       flap = 1'b0;
  logic       draw_done;
  logic       draw_enable, draw_erase, crashed;
  logic [7:0] obj_x;
  logic [6:0] obj_y;

  int tests = 0;
  int fails = 0;
  int dcnt;

  // reference model: position, crash flag and a flap carried into the next frame
  int m_y;
  bit m_crash;
  bit m_pend;

  always #5 clk = ~clk;

  heli_motion_ctrl #(
    .FRAME_CYCLES(8)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .go          (go),
    .flap        (flap),
    .draw_done   (draw_done),
    .draw_enable (draw_enable),
    .draw_erase  (draw_erase),
    .obj_x       (obj_x),
    .obj_y       (obj_y),
    .crashed     (crashed)
  );

  // drawer model: done pulses 5 cycles after enable rises
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dcnt      <= 0;
      draw_done <= 1'b0;
    end else if (!draw_enable) begin
      dcnt      <= 0;
      draw_done <= 1'b0;
    end else begin
      dcnt      <= dcnt + 1;
      draw_done <= (dcnt == 4);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_en"}, draw_enable, 0);
    check({tag, "_er"}, draw_erase, 0);
    check({tag, "_x"}, obj_x, 60);
    check({tag, "_y"}, obj_y, 50);
    check({tag, "_crash"}, crashed, 0);
  endtask

  // advance negedges until the drawer controls match; bounded
  task automatic wait_for(input logic en, input logic er, input string tag, output int n);
    n = 0;
    while (!(draw_enable === en && draw_erase === er) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check({tag, "_timeout"}, {draw_enable, draw_erase}, {en, er});
  endtask

  task automatic do_reset();
    go = 1'b0;
    flap = 1'b0;
    resetn = 1'b0;
    #1;
    check_reset_vals("async_rst");
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    m_y = 50;
    m_crash = 0;
    m_pend = 0;
  endtask

  task automatic idle_hold();
    logic seen;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      seen |= draw_enable;
    end
    check("idle_no_enable", seen, 0);
    check("idle_y", obj_y, 50);
  endtask

  // go -> first DRAW pass; returns at the first WAIT_FRAME cycle
  task automatic start_game();
    int n;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    check("go_en", draw_enable, 1);
    check("go_er", draw_erase, 0);
    check("go_y", obj_y, m_y);
    wait_for(1'b0, 1'b0, "first_draw_end", n);
  endtask

  // one frame: mode 0 none, 1 flap in wait, 2 flap in update, 3 flap in draw (ignored)
  task automatic run_frame(input int mode);
    int  k;
    int  n;
    bit  pend;
    k = 0;
    if (mode == 1) begin
      k = $urandom_range(0, 5);
      repeat (k) @(negedge clk);
      flap = 1'b1;
      @(negedge clk);
      flap = 1'b0;
      k = k + 1;
    end
    wait_for(1'b1, 1'b1, "erase_start", n);
    check("wait_len", k + n, 8);
    check("y_hold_erase", obj_y, m_y);
    wait_for(1'b0, 1'b0, "erase_end", n);
    flap = (mode == 2);
    @(negedge clk);
    flap = 1'b0;
    pend = m_pend || (mode == 1);
    if (pend) begin
      m_y = m_y - 3;
      if (m_y < 0) m_y = 0;
    end else begin
      m_y = m_y + 1;
      if (m_y > 109) m_y = 109;
    end
    if (m_y == 109 || (pend && m_y == 0)) m_crash = 1;
    m_pend = (mode == 2);
    check("redraw_ctl", {draw_enable, draw_erase}, 2'b10);
    check("new_y", obj_y, m_y);
    check("crash_flag", crashed, m_crash);
    if (mode == 3) begin
      flap = 1'b1;
      @(negedge clk);
      flap = 1'b0;
    end
    wait_for(1'b0, 1'b0, "draw_end", n);
  endtask

  task automatic crash_hold();
    logic seen;
    seen = 1'b0;
    go = 1'b1;
    flap = 1'b1;
    repeat (20) begin
      @(negedge clk);
      seen |= draw_enable;
    end
    go = 1'b0;
    flap = 1'b0;
    check("crash_no_enable", seen, 0);
    check("crash_y_frozen", obj_y, m_y);
    check("crash_sticky", crashed, 1);
  endtask

  initial begin
    int n;
    #2;
    do_reset();
    idle_hold();
    start_game();

    // plain falling, then a flap, then falling again
    repeat (3) run_frame(0);
    check("fall3_y", obj_y, 53);
    run_frame(1);
    check("flap_y", obj_y, 50);
    run_frame(0);

    // reset in the middle of an erase pass
    wait_for(1'b1, 1'b1, "erase_for_reset", n);
    @(negedge clk);
    do_reset();
    idle_hold();
    start_game();

    // random mix of flap timings
    for (int i = 0; i < 40 && !m_crash; i++) run_frame($urandom_range(0, 3));
    if (m_crash) crash_hold();

    // ceiling: 52 rising by 3 passes through 1 and saturates at 0
    do_reset();
    start_game();
    run_frame(0);
    run_frame(0);
    for (int i = 0; i < 30 && !m_crash; i++) run_frame(1);
    check("ceil_y", obj_y, 0);
    crash_hold();

    // floor: fall all the way to 109
    do_reset();
    start_game();
    for (int i = 0; i < 80 && !m_crash; i++) run_frame(0);
    check("floor_y", obj_y, 109);
    crash_hold();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1, "watchdog");
  end

endmodule
